// File: rtl/sum_window_avg.sv
// Sliding-window moving average over the adder's sum stream, valid/ready on both sides.
// Optional round-half-up averaging is enabled by defining SUM_WINDOW_AVG_ROUND_EN.
module sum_window_avg #(
  parameter int DATA_W   = 17,
  parameter int WIN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              win_full
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam int SUM_W = DATA_W + WIN_LOG2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WIN_LOG2-1:0] wp_q, wp_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                win_full_q, win_full_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic              accept;
  logic              wr_en;
  logic [SUM_W-1:0]  sum_next;
  logic [DATA_W-1:0] avg;

  always_comb begin
    in_ready = !rst && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    wr_en    = accept && !flush;

    // Once full, the slot about to be overwritten holds the oldest sample.
    if (state_q == S_FULL) begin
      sum_next = sum_q + SUM_W'(in_data) - SUM_W'(mem_q[wp_q]);
    end else begin
      sum_next = sum_q + SUM_W'(in_data);
    end

`ifdef SUM_WINDOW_AVG_ROUND_EN
    avg = DATA_W'(({1'b0, sum_next} + (SUM_W + 1)'(DEPTH / 2)) >> WIN_LOG2);
`else
    avg = DATA_W'(sum_next >> WIN_LOG2);
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d     = state_q;
    count_d     = count_q;
    wp_d        = wp_q;
    sum_d       = sum_q;
    win_full_d  = win_full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;

    if (flush) begin
      state_d    = S_EMPTY;
      count_d    = '0;
      wp_d       = '0;
      sum_d      = '0;
      win_full_d = 1'b0;
    end else if (accept) begin
      wp_d  = wp_q + WIN_LOG2'(1);
      sum_d = sum_next;
      if (count_q != DEPTH_C) count_d = count_q + CNT_W'(1);
      unique case (state_q)
        S_EMPTY: state_d = (count_d == DEPTH_C) ? S_FULL : S_FILL;
        S_FILL:  state_d = (count_d == DEPTH_C) ? S_FULL : S_FILL;
        default: state_d = S_FULL;
      endcase
      win_full_d = (count_d == DEPTH_C);
      if (count_d == DEPTH_C) begin
        out_valid_d = 1'b1;
        out_data_d  = avg;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      count_q     <= '0;
      wp_q        <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      win_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wp_q        <= wp_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      win_full_q  <= win_full_d;
    end
  end

  // NOTE: the sample buffer is deliberately not reset; the fill count decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_full  = win_full_q;

endmodule

// File: doc/sum_window_avg.md
# sum_window_avg

Streaming moving-average stage that sits directly downstream of the four-input `adder`. It consumes the adder's 17-bit sum stream and keeps a sliding window of the last 2^WIN_LOG2 accepted sums. Once the window is full, it emits one registered average per accepted sample through a valid/ready output port.

## Interface
- `DATA_W`, default 17: width of the input sum and of the output average; matches the adder output width.
- `WIN_LOG2`, default 2: log2 of the window depth; default window is 4 samples.
- `clk`  input  1: the only clock; all logic is rising-edge.
- `rst`  input  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`  input  1: `in_data` holds a sum to be accepted.
- `in_data`  input  DATA_W: unsigned sum from the adder.
- `in_ready`  output  1: the stage can accept a sample this cycle.
- `flush`  input  1: synchronously empties the window.
- `out_valid`  output  1: `out_data` holds a valid average.
- `out_data`  output  DATA_W: unsigned window average.
- `out_ready`  input  1: the downstream stage takes `out_data` this cycle.
- `win_full`  output  1: the window holds 2^WIN_LOG2 samples.

## Operation
- Storage:
  - circular buffer of 2^WIN_LOG2 entries × DATA_W
  - write pointer, WIN_LOG2 bits, wraps modulo depth
  - fill counter, 0..2^WIN_LOG2, saturating
  - running sum, DATA_W+WIN_LOG2 bits
- Accept condition: `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and is forced to 0 while `rst` is high.
- FSM states:
  - EMPTY: count = 0.
  - FILL: 0 < count < 2^WIN_LOG2.
  - FULL: count = 2^WIN_LOG2.
- Transitions:
  - EMPTY→FILL on accept.
  - FILL→FULL on the accept that makes count = depth.
  - FULL stays in FULL on accept.
  - Any state→EMPTY on `flush`.
- On accept:
  - `buf[wp] <= in_data` and `wp <= wp+1`.
  - In EMPTY or FILL: `sum <= sum + in_data`.
  - In FULL: `sum <= sum + in_data - buf[wp]`, i.e. the oldest entry is evicted.
- Output generation:
  - An average is produced only for an accept that leaves the FSM in FULL. This includes the filling accept and every later one.
  - The average is computed from the updated sum: `out_data <= sum_next >> WIN_LOG2` (see Configuration for rounding).
  - `out_valid` is set when such an average is produced.
  - The average is not widened: it is always ≤ 2^DATA_W − 1.
- Arithmetic: unsigned only. The running sum never overflows because its width is DATA_W+WIN_LOG2.
- `flush`:
  - clears count, `wp` and `sum`.
  - deasserts `win_full`.
  - does not clear buffer contents.
  - does not drop an already-registered output: `out_valid`/`out_data` hold until the handshake completes.
- `flush` together with an accept in the same cycle: `flush` wins and the sample is discarded.
- While `out_valid && !out_ready`: `out_data` and `out_valid` stay stable, `in_ready` = 0 and no sample is accepted.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `win_full`=0, `in_ready`=0.
  - `sum`=0, `wp`=0, count=0, state EMPTY.
- Reset mid-operation discards the window and any pending output on the same edge.
- Latency: an accept on edge N makes `out_valid`=1 with the new average after edge N (visible in cycle N+1).
- Throughput: one sample per cycle while `out_ready` is held at 1.
- `win_full` is registered and rises after the filling accept, in the same cycle as the first `out_valid`.
- Output handshake completes on an edge where `out_valid && out_ready`.
  - If an accept occurs on that same edge, `out_valid` stays 1 with the new data.
  - Otherwise `out_valid` drops to 0.

## Configuration
- Macro `SUM_WINDOW_AVG_ROUND_EN`.
- Defined: round half up, `out_data = (sum_next + 2^(WIN_LOG2-1)) >> WIN_LOG2`. Add one bit of headroom internally; the result still saturates naturally at 2^DATA_W − 1 for all-max inputs.
- Undefined: truncate, `out_data = sum_next >> WIN_LOG2`.

## Test plan
- Reset and fill (default parameters, `out_ready`=1):
  - Release `rst`, then feed 4444 ×4.
  - No `out_valid` during the first 3 accepts.
  - After the 4th accept, `out_data`=4444 and `win_full`=1.
- Slide:
  - Continuing from the fill test, feed 13332 then 22220.
  - Outputs are 6666 then 11110 (sums 26664 and 44440).
- Rounding:
  - After a flush, feed 1, 1, 2, 2 (sum 6).
  - Output is 1 without the macro and 2 with `SUM_WINDOW_AVG_ROUND_EN`.
- Maximum values: feed 131071 ×4 → 131071 in both builds, with no wrap.
- Backpressure:
  - Hold `out_ready`=0 with `in_valid`=1.
  - `in_ready`=0 and `out_data` stays stable for 5 cycles.
  - Raise `out_ready`: exactly one new sample is accepted per cycle and no sample is lost or duplicated.
- Flush and reset collisions:
  - Assert `flush` together with `in_valid` while in FULL.
  - The sample is dropped and `win_full` goes to 0.
  - The next 3 accepts produce no output.
  - Asserting `rst` mid-stream clears `out_valid` on the next edge.
